// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin bus arbiter with bounded burst length
module bus_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_MemRead,
    input  logic        m0_MemWrite,
    input  logic [31:0] m0_Address,
    input  logic [31:0] m0_Write_data,
    output logic [31:0] m0_Read_data,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_MemRead,
    input  logic        m1_MemWrite,
    input  logic [31:0] m1_Address,
    input  logic [31:0] m1_Write_data,
    output logic [31:0] m1_Read_data,
    output logic        m1_ack,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] Write_data,
    input  logic [31:0] Read_data,
    output logic        grant_valid,
    output logic        grant_id
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_BURST - 1);
    logic          last_id;
    logic [CW-1:0] burst_cnt;
    logic          hreq, oreq, act;
    assign hreq = grant_id ? m1_req : m0_req;
    assign oreq = grant_id ? m0_req : m1_req;
    assign act  = grant_valid & hreq;
    always_comb begin
        m0_ack       = act & ~grant_id;
        m1_ack       = act & grant_id;
        MemRead      = act & (grant_id ? m1_MemRead : m0_MemRead);
        MemWrite     = act & (grant_id ? m1_MemWrite : m0_MemWrite);
        Address      = grant_valid ? (grant_id ? m1_Address : m0_Address) : '0;
        Write_data   = grant_valid ? (grant_id ? m1_Write_data : m0_Write_data) : '0;
        m0_Read_data = m0_ack ? Read_data : '0;
        m1_Read_data = m1_ack ? Read_data : '0;
    end
    // Switch cases collapse: any live grant with the other master waiting hands over
    // unless the holder is still requesting inside its burst budget.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_valid <= 1'b0;
            grant_id    <= 1'b0;
            last_id     <= 1'b1;
            burst_cnt   <= '0;
        end else if (act && (!oreq || burst_cnt < CMAX)) begin
            burst_cnt <= (burst_cnt == CMAX) ? CMAX : burst_cnt + 1'b1;
        end else if (grant_valid && oreq) begin
            grant_id  <= ~grant_id;
            last_id   <= grant_id;
            burst_cnt <= '0;
        end else if (m0_req || m1_req) begin
            grant_valid <= 1'b1;
            grant_id    <= (m0_req && m1_req) ? ~last_id : m1_req;
            burst_cnt   <= '0;
        end else begin
            grant_valid <= 1'b0;
            last_id     <= grant_valid ? grant_id : last_id;
            burst_cnt   <= '0;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: checks MAX_BURST=4 and MAX_BURST=1 arbiters against a tenure-based model
module tb_bus_arbiter;
    logic        clk = 1'b0, reset = 1'b1, chk_en = 1'b0;
    logic        m0_req = 0, m0_MemRead = 0, m0_MemWrite = 0;
    logic        m1_req = 0, m1_MemRead = 0, m1_MemWrite = 0;
    logic [31:0] m0_Address = 0, m0_Write_data = 0, m1_Address = 0, m1_Write_data = 0;
    logic [31:0] a_m0_rd, a_m1_rd, a_addr, a_wdata, a_rdata;
    logic [31:0] b_m0_rd, b_m1_rd, b_addr, b_wdata, b_rdata;
    logic        a_m0_ack, a_m1_ack, a_rd_en, a_wr_en, a_gv, a_gid;
    logic        b_m0_ack, b_m1_ack, b_rd_en, b_wr_en, b_gv, b_gid;
    logic [31:0] mem [16];
    int          tests = 0, fails = 0;
    int          holder [2];
    int          last [2];
    int          tacks [2];

    always #5 clk = ~clk;

    bus_arbiter #(.MAX_BURST(4)) dut_a (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_MemRead(m0_MemRead), .m0_MemWrite(m0_MemWrite),
        .m0_Address(m0_Address), .m0_Write_data(m0_Write_data),
        .m0_Read_data(a_m0_rd), .m0_ack(a_m0_ack),
        .m1_req(m1_req), .m1_MemRead(m1_MemRead), .m1_MemWrite(m1_MemWrite),
        .m1_Address(m1_Address), .m1_Write_data(m1_Write_data),
        .m1_Read_data(a_m1_rd), .m1_ack(a_m1_ack),
        .MemRead(a_rd_en), .MemWrite(a_wr_en), .Address(a_addr), .Write_data(a_wdata),
        .Read_data(a_rdata), .grant_valid(a_gv), .grant_id(a_gid));

    bus_arbiter #(.MAX_BURST(1)) dut_b (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_MemRead(m0_MemRead), .m0_MemWrite(m0_MemWrite),
        .m0_Address(m0_Address), .m0_Write_data(m0_Write_data),
        .m0_Read_data(b_m0_rd), .m0_ack(b_m0_ack),
        .m1_req(m1_req), .m1_MemRead(m1_MemRead), .m1_MemWrite(m1_MemWrite),
        .m1_Address(m1_Address), .m1_Write_data(m1_Write_data),
        .m1_Read_data(b_m1_rd), .m1_ack(b_m1_ack),
        .MemRead(b_rd_en), .MemWrite(b_wr_en), .Address(b_addr), .Write_data(b_wdata),
        .Read_data(b_rdata), .grant_valid(b_gv), .grant_id(b_gid));

    // Slaves: a small RAM behind dut_a, an address-derived pattern behind dut_b
    assign a_rdata = mem[a_addr[5:2]];
    assign b_rdata = b_addr ^ 32'h5A5A_5A5A;
    always @(posedge clk) begin
        if (reset) mem <= '{default: 32'h0};
        else if (a_wr_en) mem[a_addr[5:2]] <= a_wdata;
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: tenure = acks granted since the holder won the bus;
    // a waiting master takes over once the tenure reaches the burst limit.
    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 2; k++) begin : mdl
            int h, t, l, nh, nt, nl, mb;
            logic [1:0] r;
            mb = (k == 0) ? 4 : 1;
            r = {m1_req, m0_req};
            h = holder[k]; t = tacks[k]; l = last[k];
            nh = h; nt = t; nl = l;
            if (reset) begin
                nh = -1; nt = 0; nl = 1;
            end else begin
                if (h >= 0 && r[h]) t = t + 1;
                nt = t;
                if (h >= 0 && r[1-h] && (!r[h] || t >= mb)) begin
                    nl = h; nh = 1 - h; nt = 0;
                end else if (h >= 0 && r[h]) begin
                    nh = h;
                end else if (r[0] && r[1]) begin
                    nh = 1 - l; nt = 0;
                end else if (r[0] || r[1]) begin
                    nh = r[0] ? 0 : 1; nt = 0;
                end else begin
                    if (h >= 0) nl = h;
                    nh = -1; nt = 0;
                end
            end
            holder[k] <= nh; tacks[k] <= nt; last[k] <= nl;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin : chk
                int h;
                logic act;
                logic [31:0] ea, ed, erd;
                h = holder[k];
                act = (h >= 0) && (h == 1 ? m1_req : m0_req) && !reset;
                ea = (h >= 0 && !reset) ? (h == 1 ? m1_Address : m0_Address) : 32'h0;
                ed = (h >= 0 && !reset) ? (h == 1 ? m1_Write_data : m0_Write_data) : 32'h0;
                erd = act ? (k == 0 ? mem[ea[5:2]] : ea ^ 32'h5A5A_5A5A) : 32'h0;
                check(k ? "b_gv" : "a_gv", 32'(k ? b_gv : a_gv), 32'(h >= 0));
                if (h >= 0) check(k ? "b_gid" : "a_gid", 32'(k ? b_gid : a_gid), 32'(h));
                check(k ? "b_ack0" : "a_ack0", 32'(k ? b_m0_ack : a_m0_ack), 32'(act && h == 0));
                check(k ? "b_ack1" : "a_ack1", 32'(k ? b_m1_ack : a_m1_ack), 32'(act && h == 1));
                check(k ? "b_rd_en" : "a_rd_en", 32'(k ? b_rd_en : a_rd_en),
                      32'(act && (h == 1 ? m1_MemRead : m0_MemRead)));
                check(k ? "b_wr_en" : "a_wr_en", 32'(k ? b_wr_en : a_wr_en),
                      32'(act && (h == 1 ? m1_MemWrite : m0_MemWrite)));
                check(k ? "b_addr" : "a_addr", k ? b_addr : a_addr, ea);
                check(k ? "b_wdata" : "a_wdata", k ? b_wdata : a_wdata, ed);
                check(k ? "b_rd0" : "a_rd0", k ? b_m0_rd : a_m0_rd, h == 0 ? erd : 32'h0);
                check(k ? "b_rd1" : "a_rd1", k ? b_m1_rd : a_m1_rd, h == 1 ? erd : 32'h0);
            end
        end
    end

    typedef struct {
        bit r0, r1, a0, a1, b0, b1;
    } vec_t;
    vec_t tbl [15];

    initial begin
        int n, bad, got;
        tbl = '{'{1,1,0,0,0,0}, '{1,1,1,0,1,0}, '{1,1,1,0,0,1}, '{1,1,1,0,1,0},
                '{1,1,1,0,0,1}, '{1,1,0,1,1,0}, '{1,1,0,1,0,1}, '{1,1,0,1,1,0},
                '{1,1,0,1,0,1}, '{1,1,1,0,1,0}, '{0,0,0,0,0,0}, '{0,1,0,0,0,0},
                '{0,1,0,1,0,1}, '{1,1,0,1,0,1}, '{1,1,0,1,1,0}};
        repeat (2) tick();
        @(negedge clk);
        check("rst_gv", 32'({a_gv, b_gv}), 32'h0);
        check("rst_ack", 32'({a_m0_ack, a_m1_ack, b_m0_ack, b_m1_ack}), 32'h0);
        check("rst_strobe", 32'({a_rd_en, a_wr_en, b_rd_en, b_wr_en}), 32'h0);
        check("rst_addr", a_addr | a_wdata | b_addr | b_wdata, 32'h0);
        tick();
        reset = 1'b0;
        chk_en = 1'b1;
        // write then read through master 0
        m0_req = 1; m0_MemWrite = 1; m0_Address = 32'h4; m0_Write_data = 32'hDEADBEEF;
        @(negedge clk);
        check("wr_idle_ack", 32'(a_m0_ack), 32'h0);
        tick();
        @(negedge clk);
        check("wr_ack", 32'(a_m0_ack), 32'h1);
        check("wr_strobe", 32'(a_wr_en), 32'h1);
        check("wr_addr", a_addr, 32'h4);
        check("wr_data", a_wdata, 32'hDEADBEEF);
        tick();
        m0_MemWrite = 0; m0_MemRead = 1;
        @(negedge clk);
        check("rd_ack", 32'(a_m0_ack), 32'h1);
        check("rd_data", a_m0_rd, 32'hDEADBEEF);
        // holder drops req for one cycle
        tick();
        m0_req = 0; m0_MemWrite = 1;
        @(negedge clk);
        check("drop_strobe", 32'({a_rd_en, a_wr_en}), 32'h0);
        tick();
        m0_req = 1; m0_MemWrite = 0;
        tick();
        @(negedge clk);
        check("rereq_ack", 32'(a_m0_ack), 32'h1);
        check("rereq_gid", 32'(a_gid), 32'h0);
        tick();
        m0_req = 0; m0_MemRead = 0;
        reset = 1;
        tick();
        reset = 0;
        // contention table
        m0_MemRead = 1; m1_MemRead = 1;
        foreach (tbl[i]) begin
            m0_req = tbl[i].r0; m1_req = tbl[i].r1;
            @(negedge clk);
            check($sformatf("tbl%0d_a0", i), 32'(a_m0_ack), 32'(tbl[i].a0));
            check($sformatf("tbl%0d_a1", i), 32'(a_m1_ack), 32'(tbl[i].a1));
            check($sformatf("tbl%0d_b0", i), 32'(b_m0_ack), 32'(tbl[i].b0));
            check($sformatf("tbl%0d_b1", i), 32'(b_m1_ack), 32'(tbl[i].b1));
            tick();
        end
        m0_req = 0; m1_req = 0;
        tick();
        // m1 streams alone, then m0 joins
        m1_req = 1; m1_Address = 32'h4000_0010;
        tick();
        n = 0; bad = 0;
        repeat (10) begin
            @(negedge clk);
            n += int'(a_m1_ack);
            bad += int'(a_m0_ack);
            tick();
        end
        check("m1_stream_acks", 32'(n), 32'd10);
        check("m1_stream_m0", 32'(bad), 32'd0);
        m0_req = 1;
        got = 0;
        for (int c = 0; c < 6 && got == 0; c++) begin
            @(negedge clk);
            got = int'(a_m0_ack);
            tick();
        end
        check("m0_after_m1", 32'(got), 32'd1);
        m0_req = 0; m1_req = 0; m0_MemRead = 0; m1_MemRead = 0;
        tick();
        // async reset in the middle of an m1 write burst
        m1_req = 1; m1_MemWrite = 1; m1_Address = 32'h8; m1_Write_data = 32'h1234_5678;
        got = 0;
        for (int c = 0; c < 5 && got == 0; c++) begin
            @(negedge clk);
            got = int'(a_m1_ack);
            if (got == 0) tick();
        end
        check("mid_m1_granted", 32'(got), 32'd1);
        #2 reset = 1;
        #1;
        check("mid_rst_wr", 32'({a_wr_en, b_wr_en}), 32'h0);
        check("mid_rst_ack", 32'({a_m1_ack, b_m1_ack}), 32'h0);
        check("mid_rst_gv", 32'({a_gv, b_gv}), 32'h0);
        m1_MemWrite = 0; m0_req = 1; m0_MemRead = 1; m1_MemRead = 1;
        tick();
        reset = 0;
        got = 0;
        for (int c = 0; c < 5 && got == 0; c++) begin
            @(negedge clk);
            got = int'(a_m0_ack | a_m1_ack);
            if (got != 0) begin
                check("post_rst_a_m0", 32'({a_m0_ack, a_m1_ack}), 32'h2);
                check("post_rst_b_m0", 32'({b_m0_ack, b_m1_ack}), 32'h2);
            end
            tick();
        end
        check("post_rst_any", 32'(got), 32'd1);
        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            m0_req = ($urandom_range(0, 3) != 0);
            m1_req = ($urandom_range(0, 3) != 0);
            m0_MemRead = 1'($urandom); m0_MemWrite = 1'($urandom);
            m1_MemRead = 1'($urandom); m1_MemWrite = 1'($urandom);
            m0_Address = $urandom & 32'hFFFF_FFFC; m1_Address = $urandom & 32'hFFFF_FFFC;
            m0_Write_data = $urandom; m1_Write_data = $urandom;
            if ($urandom_range(0, 499) == 0) #2 reset = 1;
            tick();
            reset = 0;
        end
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Two-master arbiter that shares the single memory-mapped peripheral bus (data memory, BCD, UART) between master 0 (CPU MEM stage) and master 1 (DMA/boot loader). It uses registered round-robin grant with a bounded burst length, so neither master can starve the other. It sits directly in front of the bus decoder. The slave side is single-cycle: reads are combinational, writes commit on the rising edge.

Parameters:
MAX_BURST, 4, maximum consecutive acked transfers a holder keeps while the other master is requesting (legal range 1..255).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
m0_req  in  1  master 0 transfer request; held with command until m0_ack
m0_MemRead  in  1  master 0 read command
m0_MemWrite  in  1  master 0 write command
m0_Address  in  32  master 0 byte address
m0_Write_data  in  32  master 0 write data
m0_Read_data  out  32  master 0 read data; valid when m0_ack
m0_ack  out  1  master 0 transfer completes this cycle
m1_req, m1_MemRead, m1_MemWrite, m1_Address, m1_Write_data, m1_Read_data, m1_ack  same as m0_*, for master 1
MemRead  out  1  bus read strobe
MemWrite  out  1  bus write strobe
Address  out  32  bus address
Write_data  out  32  bus write data
Read_data  in  32  bus read data (combinational from slave)
grant_valid  out  1  a master currently holds the bus
grant_id  out  1  holder index (0/1); meaningful only when grant_valid

Behaviour:
- Registered state: grant_valid, grant_id, last_id, burst_cnt (ceil(log2(MAX_BURST+1)) bits).
- Async reset values: grant_valid=0, grant_id=0, last_id=1 (master 0 wins the first tie), burst_cnt=0. All outputs are 0 while reset is high, including mid-transfer.
- Combinational outputs, with g=grant_id and act = grant_valid & mg_req:
  - mg_ack = act.
  - MemRead = act & mg_MemRead; MemWrite = act & mg_MemWrite.
  - Address and Write_data = granted master's values when grant_valid, else 0.
  - mg_Read_data = Read_data when act, else 0. The non-granted master sees ack=0 and Read_data=0.
- Arbitration is evaluated at each rising edge from the current req inputs and state:
  - Holder requesting, and (other idle or burst_cnt < MAX_BURST-1): keep grant. burst_cnt += 1 if act.
  - Holder requesting, other requesting, burst_cnt >= MAX_BURST-1: switch grant_id to the other master. last_id = old holder; burst_cnt = 0.
  - Holder not requesting, other requesting: switch, same updates as above.
  - No grant or holder idle, both requesting: grant to ~last_id; burst_cnt = 0.
  - Only one master requesting: grant to it.
  - Neither requesting: grant_valid = 0. last_id keeps the last holder; burst_cnt = 0.
- Latency:
  - Request from an idle arbiter (req rises in cycle N): ack in cycle N+1.
  - Holder with continuous req: one ack per cycle, back-to-back.
  - Handover after a burst: first ack for the new master in the cycle following the holder's final ack. No dead cycle.
- A holder that drops req while granted issues no bus strobe that cycle. Grant follows the rules above.
- MemRead and MemWrite both set: both are forwarded unchanged. The write commits at the edge; read data reflects the pre-write value.
- MAX_BURST=1: strict alternation whenever both masters request.
- burst_cnt never exceeds MAX_BURST-1 (saturating).

Test Plan:
- Reset → all outputs 0, grant_valid=0. m0 write 0x0000_0004←0xDEADBEEF: req in cycle 1, ack in cycle 2 with MemWrite=1, Address=0x4, Write_data=0xDEADBEEF. m0 read 0x4 → m0_Read_data=0xDEADBEEF on ack.
- Both masters raise req in the same cycle after reset → master 0 acked first. With MAX_BURST=4, m0 gets 4 acks, then m1 gets 4 acks, then alternation continues in blocks of 4 with no idle cycles.
- m1 alone issues 10 back-to-back reads of 0x4000_0010 → 10 consecutive m1_acks and m0_ack=0 throughout. m0 then requests → m0 granted no later than after the 4th m1 ack following m0's request.
- m0 holds the bus and drops req for one cycle while m1 is idle → MemRead=MemWrite=0 that cycle. m0 re-requests → acked the next cycle, grant_id stays 0.
- reset asserted mid-burst (m1 granted, MemWrite=1) → MemWrite, m1_ack and grant_valid fall immediately (asynchronously). After release with both masters requesting, m0 wins (last_id=1).
- MAX_BURST=1, both masters requesting continuously for 6 cycles → ack sequence m0,m1,m0,m1,m0,m1.
